wishbone_master_port: RTL and testbench

Single-transfer Wishbone initiator that converts a simple command/response handshake into classic Wishbone read and write cycles. It drives the master side of the Wishbone interconnect, where address bits [31:24] select the slave. It adds a bus-timeout abort so a missing ack cannot hang the host. It also latches the rising edge of the interconnect's interrupt line into a sticky pending flag. It sits between host-side logic (UART/USB command decoder) and the interconnect.

---
 rtl/wishbone_master_port.sv | 109 ++++++++++
 tb/tb_wishbone_master_port.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_master_port.sv
// Single-transfer classic Wishbone initiator with a bus-timeout abort and a
// sticky rising-edge interrupt flag. It bridges a host command/response handshake.
module wishbone_master_port #(
    parameter logic [15:0] TIMEOUT = 16'd256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_stb_i,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    output logic        cmd_busy_o,
    output logic        rsp_stb_o,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        int_pending_o,
    input  logic        int_clr_i,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_int_i
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [15:0] TMO_LIMIT = TIMEOUT - 16'd1;

    state_t      state;
    logic [15:0] tmo_cnt;
    logic        int_sync;
    logic        int_hist;

    // cyc, stb and busy are all a direct view of the one-bit state register,
    // so they drop the instant reset is asserted.
    assign cmd_busy_o = (state == ACTIVE);
    assign wbm_cyc_o  = (state == ACTIVE);
    assign wbm_stb_o  = (state == ACTIVE);

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            tmo_cnt   <= 16'd0;
            rsp_stb_o <= 1'b0;
            rsp_dat_o <= 32'd0;
            rsp_err_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= 32'd0;
            wbm_dat_o <= 32'd0;
        end else begin
            rsp_stb_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_stb_i) begin
                        wbm_we_o  <= cmd_we_i;
                        wbm_adr_o <= cmd_adr_i;
                        wbm_dat_o <= cmd_dat_i;
                        tmo_cnt   <= 16'd0;
                        state     <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    // Ack is tested first so it wins over a coincident timeout.
                    if (wbm_ack_i) begin
                        rsp_dat_o <= wbm_we_o ? 32'd0 : wbm_dat_i;
                        rsp_err_o <= 1'b0;
                        rsp_stb_o <= 1'b1;
                        state     <= IDLE;
                    end else if ((TIMEOUT != 16'd0) && (tmo_cnt == TMO_LIMIT)) begin
                        rsp_dat_o <= 32'd0;
                        rsp_err_o <= 1'b1;
                        rsp_stb_o <= 1'b1;
                        state     <= IDLE;
                    end else if (tmo_cnt != 16'hFFFF) begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Interrupt line is registered once, then compared with its delayed copy;
    // a set in the same cycle as a clear takes priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_sync      <= 1'b0;
            int_hist      <= 1'b0;
            int_pending_o <= 1'b0;
        end else begin
            int_sync <= wbm_int_i;
            int_hist <= int_sync;
            if (int_sync && !int_hist) begin
                int_pending_o <= 1'b1;
            end else if (int_clr_i) begin
                int_pending_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wishbone_master_port.sv
// Directed bench for wishbone_master_port: u_dut uses TIMEOUT=4, u_dut0 uses
// TIMEOUT=0. Inputs change and outputs are sampled on the falling clock edge.
module tb_wishbone_master_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_stb, cmd_stb0;
    logic        cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic        int_clr;
    logic [31:0] wbm_dat_i;
    logic        ack, ack0;
    logic        wbm_int;

    logic        busy, rsp_stb, rsp_err, int_pend, we, cyc, stb;
    logic [31:0] rsp_dat, adr, dat;
    logic        busy0, rsp_stb0, rsp_err0, int_pend0, we0, cyc0, stb0;
    logic [31:0] rsp_dat0, adr0, dat0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wishbone_master_port #(.TIMEOUT(16'd4)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_stb_i(cmd_stb), .cmd_we_i(cmd_we), .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
        .cmd_busy_o(busy), .rsp_stb_o(rsp_stb), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
        .int_pending_o(int_pend), .int_clr_i(int_clr),
        .wbm_we_o(we), .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_adr_o(adr), .wbm_dat_o(dat),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(ack), .wbm_int_i(wbm_int)
    );

    wishbone_master_port #(.TIMEOUT(16'd0)) u_dut0 (
        .clk(clk), .rst(rst),
        .cmd_stb_i(cmd_stb0), .cmd_we_i(cmd_we), .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
        .cmd_busy_o(busy0), .rsp_stb_o(rsp_stb0), .rsp_dat_o(rsp_dat0), .rsp_err_o(rsp_err0),
        .int_pending_o(int_pend0), .int_clr_i(int_clr),
        .wbm_we_o(we0), .wbm_cyc_o(cyc0), .wbm_stb_o(stb0), .wbm_adr_o(adr0), .wbm_dat_o(dat0),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(ack0), .wbm_int_i(wbm_int)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
        cmd_stb = 1'b1;
        cmd_we  = w;
        cmd_adr = a;
        cmd_dat = d;
    endtask

    initial begin
        rst = 1'b0; cmd_stb = 1'b0; cmd_stb0 = 1'b0; cmd_we = 1'b0;
        cmd_adr = 32'd0; cmd_dat = 32'd0; int_clr = 1'b0; wbm_dat_i = 32'd0;
        ack = 1'b0; ack0 = 1'b0; wbm_int = 1'b0;

        // Reset state
        tick();
        check("rst_busy", busy, 0);
        check("rst_cyc", cyc, 0);
        check("rst_rsp_stb", rsp_stb, 0);
        check("rst_rsp_dat", rsp_dat, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_int", int_pend, 0);
        check("rst_adr", adr, 0);
        check("rst_we", we, 0);
        rst = 1'b1;
        tick();

        // Write with ack in cycle 3; inputs change after acceptance to prove holding
        issue(1'b1, 32'h0100_0004, 32'hDEAD_BEEF);
        wbm_dat_i = 32'hFFFF_FFFF;
        tick(); // cycle 1
        cmd_stb = 1'b0; cmd_we = 1'b0; cmd_adr = 32'h1111_1111; cmd_dat = 32'h2222_2222;
        check("wr_c1_cyc", cyc, 1);
        check("wr_c1_stb", stb, 1);
        check("wr_c1_we", we, 1);
        check("wr_c1_adr", adr, 32'h0100_0004);
        check("wr_c1_dat", dat, 32'hDEAD_BEEF);
        check("wr_c1_busy", busy, 1);
        tick(); // cycle 2
        check("wr_c2_adr", adr, 32'h0100_0004);
        tick(); // cycle 3
        check("wr_c3_stb", stb, 1);
        check("wr_c3_dat", dat, 32'hDEAD_BEEF);
        check("wr_c3_rsp_stb", rsp_stb, 0);
        ack = 1'b1;
        tick(); // cycle 4
        ack = 1'b0;
        check("wr_c4_rsp_stb", rsp_stb, 1);
        check("wr_c4_err", rsp_err, 0);
        check("wr_c4_rsp_dat", rsp_dat, 0);
        check("wr_c4_cyc", cyc, 0);
        check("wr_c4_busy", busy, 0);
        check("wr_c4_adr_hold", adr, 32'h0100_0004);
        tick(); // cycle 5
        check("wr_c5_rsp_stb", rsp_stb, 0);

        // Zero-wait read, busy command dropped, back-to-back command
        issue(1'b0, 32'h0000_0010, 32'd0);
        tick(); // cycle 1
        issue(1'b1, 32'h0000_0099, 32'h9999_9999);
        ack = 1'b1; wbm_dat_i = 32'h1234_5678;
        check("rd_c1_stb", stb, 1);
        check("rd_c1_we", we, 0);
        check("rd_c1_adr", adr, 32'h0000_0010);
        tick(); // cycle 2
        ack = 1'b0;
        issue(1'b0, 32'h0000_0020, 32'd0);
        check("rd_c2_rsp_stb", rsp_stb, 1);
        check("rd_c2_rsp_dat", rsp_dat, 32'h1234_5678);
        check("rd_c2_stb", stb, 0);
        tick(); // cycle 3
        cmd_stb = 1'b0;
        check("b2b_c3_stb", stb, 1);
        check("b2b_c3_adr", adr, 32'h0000_0020);
        check("b2b_c3_we", we, 0);
        ack = 1'b1; wbm_dat_i = 32'hCAFE_0001;
        tick();
        ack = 1'b0;
        check("b2b_rsp_stb", rsp_stb, 1);
        check("b2b_rsp_dat", rsp_dat, 32'hCAFE_0001);
        tick();

        // Timeout with TIMEOUT=4 and no ack
        issue(1'b0, 32'h0200_0000, 32'd0);
        tick(); // cycle 1
        cmd_stb = 1'b0;
        check("to_c1_stb", stb, 1);
        tick(); tick(); tick(); // cycle 4
        check("to_c4_stb", stb, 1);
        check("to_c4_rsp_stb", rsp_stb, 0);
        check("to_c4_dat_hold", rsp_dat, 32'hCAFE_0001);
        tick(); // cycle 5
        check("to_c5_stb", stb, 0);
        check("to_c5_cyc", cyc, 0);
        check("to_c5_rsp_stb", rsp_stb, 1);
        check("to_c5_err", rsp_err, 1);
        check("to_c5_rsp_dat", rsp_dat, 0);
        tick(); // cycle 6
        check("to_c6_rsp_stb", rsp_stb, 0);
        check("to_c6_err_hold", rsp_err, 1);

        // Ack on the limit cycle wins over the timeout
        issue(1'b0, 32'h0200_0004, 32'd0);
        tick(); // cycle 1
        cmd_stb = 1'b0;
        tick(); tick(); tick(); // cycle 4
        check("lim_c4_stb", stb, 1);
        ack = 1'b1; wbm_dat_i = 32'hA5A5_0004;
        tick(); // cycle 5
        ack = 1'b0;
        check("lim_rsp_stb", rsp_stb, 1);
        check("lim_err", rsp_err, 0);
        check("lim_rsp_dat", rsp_dat, 32'hA5A5_0004);
        tick();

        // TIMEOUT=0: ack at cycle 1000 still succeeds
        cmd_stb0 = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h0300_0008; cmd_dat = 32'h0000_1000;
        tick(); // cycle 1
        cmd_stb0 = 1'b0;
        repeat (999) tick(); // cycle 1000
        check("nt_c1000_stb", stb0, 1);
        check("nt_c1000_rsp_stb", rsp_stb0, 0);
        check("nt_c1000_adr", adr0, 32'h0300_0008);
        ack0 = 1'b1;
        tick();
        ack0 = 1'b0;
        check("nt_rsp_stb", rsp_stb0, 1);
        check("nt_err", rsp_err0, 0);
        check("nt_rsp_dat", rsp_dat0, 0);
        check("nt_busy", busy0, 0);
        tick();

        // Interrupt flag: set two cycles after the edge, no retrigger, clear
        wbm_int = 1'b1;
        tick(); // n+1
        check("int_n1", int_pend, 0);
        tick(); // n+2
        check("int_n2", int_pend, 1);
        tick(); tick();
        check("int_hold", int_pend, 1);
        int_clr = 1'b1;
        tick();
        int_clr = 1'b0;
        check("int_clr", int_pend, 0);
        tick(); tick();
        check("int_no_retrig", int_pend, 0);

        // Rising edge coincident with a clear: set wins
        wbm_int = 1'b0;
        tick(); tick();
        wbm_int = 1'b1;
        tick();
        int_clr = 1'b1;
        tick();
        int_clr = 1'b0;
        check("int_set_wins", int_pend, 1);
        int_clr = 1'b1;
        tick();
        int_clr = 1'b0;
        check("int_clr2", int_pend, 0);

        // Asynchronous reset mid-transfer
        issue(1'b1, 32'h0400_0000, 32'h0000_0055);
        tick(); // cycle 1
        cmd_stb = 1'b0;
        check("arst_pre_stb", stb, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_cyc", cyc, 0);
        check("arst_stb", stb, 0);
        check("arst_busy", busy, 0);
        check("arst_adr", adr, 0);
        tick();
        rst = 1'b1;
        check("arst_rsp_stb", rsp_stb, 0);
        tick();
        check("arst_rsp_stb2", rsp_stb, 0);

        // Normal transfer after reset release
        issue(1'b1, 32'h0500_000C, 32'h0000_0077);
        tick(); // cycle 1
        cmd_stb = 1'b0;
        check("post_c1_stb", stb, 1);
        check("post_c1_dat", dat, 32'h0000_0077);
        ack = 1'b1;
        tick(); // cycle 2
        ack = 1'b0;
        check("post_rsp_stb", rsp_stb, 1);
        check("post_err", rsp_err, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
